// File: rtl/bit_reverse_printer_pkg.sv
// Shared constants for the bit-reversal demo message block.
package bit_reverse_printer_pkg;

    // ASCII characters exchanged with the UART cores
    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_1  = 8'h31;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // FSM state encoding, exported on the debug 'state' port
    localparam logic [0:0] RECEIVE = 1'b0;
    localparam logic [0:0] PRINT   = 1'b1;

    // True for the two characters that carry a bit value
    function automatic logic isBitChar(input logic [7:0] c);
        return (c == CHAR_0) || (c == CHAR_1);
    endfunction

endpackage

// File: rtl/bit_reverse_printer_reverse8.sv
// Purely combinational 8-bit reverser: data_o[i] = data_i[7-i].
module bit_reverse8 (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Mirror the bit order of the input byte
    always_comb begin
        data_o = '0;
        for (int i = 0; i < 8; i++) begin
            data_o[i] = data_i[7-i];
        end
    end

endmodule

// File: rtl/bit_reverse_printer.sv
// Collects eight ASCII '0'/'1' characters, bit-reverses the byte and
// prints it back through the UART transmitter, optionally with CR LF.
module bit_reverse_printer
    import bit_reverse_printer_pkg::*;
#(
    parameter int NUM_BITS  = 8,
    parameter bit SEND_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    input  logic       tx_busy,
    input  logic       new_rx_data,
    input  logic [7:0] rx_data,
    output logic       state,
    output logic [3:0] addr,
    output logic       bytes,
    output logic [3:0] counter
);

    // Index of the final character of a message (last CR LF slot or last bit)
    localparam logic [3:0] LAST_ADDR = SEND_CRLF ? 4'(NUM_BITS + 1) : 4'(NUM_BITS - 1);
    localparam logic [3:0] FULL_COUNT = 4'(NUM_BITS);

    logic [0:0] state_q, state_d;
    logic [3:0] counter_q, counter_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] shiftReg_q, shiftReg_d;
    logic [7:0] revReg_q, revReg_d;
    logic [7:0] txData_q, txData_d;
    logic       newTx_q, newTx_d;

    logic [7:0] revWire;
    logic [2:0] bitSel;
    logic       selBit;
    logic [7:0] printChar;

    bit_reverse8 u_reverse (
        .data_i (shiftReg_q),
        .data_o (revWire)
    );

    // Select the reversed-byte bit for the current print slot, MSB first
    always_comb begin
        bitSel = ~addr_q[2:0];
        selBit = 1'b0;
        if (addr_q < 4'd8) begin
            selBit = revReg_q[bitSel];
        end
        if (addr_q < 4'd8) begin
            printChar = selBit ? CHAR_1 : CHAR_0;
        end else if (addr_q == 4'd8) begin
            printChar = CHAR_CR;
        end else begin
            printChar = CHAR_LF;
        end
    end

    // Next-state logic for receive assembly and paced printing
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        addr_d     = addr_q;
        shiftReg_d = shiftReg_q;
        revReg_d   = revReg_q;
        txData_d   = txData_q;
        newTx_d    = 1'b0;
        case (state_q)
            RECEIVE: begin
                if (counter_q == FULL_COUNT) begin
                    revReg_d  = revWire;
                    addr_d    = 4'd0;
                    counter_d = 4'd0;
                    state_d   = PRINT;
                end else if (new_rx_data && isBitChar(rx_data)) begin
                    shiftReg_d = {shiftReg_q[6:0], rx_data[0]};
                    counter_d  = counter_q + 4'd1;
                end
            end
            PRINT: begin
                if (newTx_q) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = RECEIVE;
                        addr_d  = 4'd0;
                    end else begin
                        addr_d = addr_q + 4'd1;
                    end
                end else if (!tx_busy) begin
                    newTx_d  = 1'b1;
                    txData_d = printChar;
                end
            end
            default: begin
                state_d = RECEIVE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RECEIVE;
            counter_q  <= 4'd0;
            addr_q     <= 4'd0;
            shiftReg_q <= 8'd0;
            revReg_q   <= 8'd0;
            txData_q   <= 8'd0;
            newTx_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            addr_q     <= addr_d;
            shiftReg_q <= shiftReg_d;
            revReg_q   <= revReg_d;
            txData_q   <= txData_d;
            newTx_q    <= newTx_d;
        end
    end

    assign tx_data     = txData_q;
    assign new_tx_data = newTx_q;
    assign state       = state_q;
    assign addr        = addr_q;
    assign counter     = counter_q;
    assign bytes       = selBit;

endmodule

// File: tb/tb_bit_reverse_printer.sv
// Directed self-checking bench for bit_reverse_printer.
module tb_bit_reverse_printer;

    typedef logic [7:0] charQ_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;
    logic       new_rx_data;
    logic [7:0] rx_data;
    logic       state;
    logic [3:0] addr;
    logic       bytes;
    logic [3:0] counter;

    int checks = 0;
    int failures = 0;
    int cycleCount = 0;
    logic [7:0] strobeQ[$];
    int strobeCyc[$];

    bit_reverse_printer dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .new_rx_data (new_rx_data),
        .rx_data     (rx_data),
        .state       (state),
        .addr        (addr),
        .bytes       (bytes),
        .counter     (counter)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Cycle index, advanced at each active edge
    always @(posedge clk) cycleCount++;

    // Capture every transmitter strobe with its cycle index
    always @(negedge clk) begin
        if (new_tx_data === 1'b1) begin
            strobeQ.push_back(tx_data);
            strobeCyc.push_back(cycleCount);
        end
    end

    function automatic charQ_t expectedPrint(input string bits);
        charQ_t q;
        for (int i = 0; i < bits.len(); i++) q.push_back(8'(bits[i]));
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // One single-cycle rx strobe; reports counter and cycle just after it is taken
    task automatic sendChar(input logic [7:0] c, output logic [3:0] cntAfter, output int cycAfter);
        @(posedge clk); #1;
        rx_data = c;
        new_rx_data = 1'b1;
        @(posedge clk); #1;
        new_rx_data = 1'b0;
        @(negedge clk); #1;
        cntAfter = counter;
        cycAfter = cycleCount;
    endtask

    task automatic waitStrobes(input int n, input int budget, output bit reached);
        reached = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (strobeQ.size() >= n) begin
                reached = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; tx_busy = 1'b0; new_rx_data = 1'b0; rx_data = 8'h00;
        strobeQ.delete(); strobeCyc.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; new_rx_data = 1'b1; rx_data = 8'h31;
            @(posedge clk); #1; new_rx_data = 1'b0;
        end
        @(negedge clk); #1;
        checks++; if (counter !== 4'd0) begin failures++; $display("[TB] FAIL reset_counter got=%0d exp=0", counter); end
        checks++; if (state !== 1'b0) begin failures++; $display("[TB] FAIL reset_state got=%0b exp=0", state); end
        checks++; if (addr !== 4'd0) begin failures++; $display("[TB] FAIL reset_addr got=%0d exp=0", addr); end
        checks++; if (new_tx_data !== 1'b0) begin failures++; $display("[TB] FAIL reset_strobe got=%0b exp=0", new_tx_data); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_txdata got=%0h exp=00", tx_data); end
        checks++; if (bytes !== 1'b0) begin failures++; $display("[TB] FAIL reset_bytes got=%0b exp=0", bytes); end
        checks++; if (strobeQ.size() != 0) begin failures++; $display("[TB] FAIL reset_no_strobe got=%0d exp=0", strobeQ.size()); end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++; if (state !== 1'b0 || counter !== 4'd0) begin failures++; $display("[TB] FAIL release_state got=%0b/%0d exp=0/0", state, counter); end
    endtask

    task automatic test_basic();
        charQ_t msg;
        charQ_t expQ;
        logic [3:0] cnt;
        int cyc;
        bit reached;
        msg = '{8'h31, 8'h30, 8'h31, 8'h30, 8'h31, 8'h30, 8'h31, 8'h30};
        expQ = expectedPrint("01010101");
        strobeQ.delete(); strobeCyc.delete();
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            sendChar(msg[i], cnt, cyc);
            checks++; if (cnt !== 4'(i + 1)) begin failures++; $display("[TB] FAIL basic_counter got=%0d exp=%0d", cnt, i + 1); end
            if (i < 7) idle(4);
        end
        @(negedge clk); #1;
        checks++; if (counter !== 4'd0 || state !== 1'b1 || addr !== 4'd0) begin failures++; $display("[TB] FAIL basic_enter_print got=%0d/%0b/%0d exp=0/1/0", counter, state, addr); end
        waitStrobes(10, 100, reached);
        checks++; if (!reached || strobeQ.size() != 10) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=10", strobeQ.size()); end
        for (int i = 0; i < strobeQ.size() && i < 10; i++) begin
            checks++; if (strobeQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL basic_char%0d got=%0h exp=%0h", i, strobeQ[i], expQ[i]); end
        end
        if (strobeCyc.size() > 0) begin
            checks++; if (strobeCyc[0] != cyc + 2) begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=%0d", strobeCyc[0] - cyc, 2); end
        end
        for (int i = 1; i < strobeCyc.size(); i++) begin
            checks++; if (strobeCyc[i] - strobeCyc[i-1] != 2) begin failures++; $display("[TB] FAIL basic_spacing%0d got=%0d exp=2", i, strobeCyc[i] - strobeCyc[i-1]); end
        end
        @(negedge clk); #1;
        checks++; if (state !== 1'b0 || addr !== 4'd0) begin failures++; $display("[TB] FAIL basic_return got=%0b/%0d exp=0/0", state, addr); end
    endtask

    task automatic test_asymmetric();
        charQ_t msg;
        charQ_t expQ;
        logic [3:0] cnt;
        int cyc;
        logic [7:0] expBytesByAddr;
        bit reached;
        bit saw6;
        bit saw7;
        msg = '{8'h31, 8'h31, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30};
        expQ = expectedPrint("00000011");
        expBytesByAddr = 8'b1100_0000;
        reached = 1'b0; saw6 = 1'b0; saw7 = 1'b0;
        idle(2);
        strobeQ.delete(); strobeCyc.delete();
        for (int i = 0; i < 8; i++) begin
            sendChar(msg[i], cnt, cyc);
            if (i < 7) idle(4);
        end
        for (int t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (state === 1'b1) begin
                if (addr == 4'd6) saw6 = 1'b1;
                if (addr == 4'd7) saw7 = 1'b1;
                if (addr < 4'd8) begin
                    checks++; if (bytes !== expBytesByAddr[addr[2:0]]) begin failures++; $display("[TB] FAIL asym_bytes addr=%0d got=%0b exp=%0b", addr, bytes, expBytesByAddr[addr[2:0]]); end
                end else begin
                    checks++; if (bytes !== 1'b0) begin failures++; $display("[TB] FAIL asym_bytes_crlf addr=%0d got=%0b exp=0", addr, bytes); end
                end
            end
            if (strobeQ.size() >= 10) begin
                reached = 1'b1;
                break;
            end
        end
        checks++; if (!(saw6 && saw7)) begin failures++; $display("[TB] FAIL asym_addr_visit got=%0b%0b exp=11", saw6, saw7); end
        checks++; if (!reached || strobeQ.size() != 10) begin failures++; $display("[TB] FAIL asym_count got=%0d exp=10", strobeQ.size()); end
        for (int i = 0; i < strobeQ.size() && i < 10; i++) begin
            checks++; if (strobeQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL asym_char%0d got=%0h exp=%0h", i, strobeQ[i], expQ[i]); end
        end
    endtask

    task automatic test_filtering();
        charQ_t msg;
        charQ_t expQ;
        logic [3:0] cnt;
        int cyc;
        int validCount;
        bit reached;
        msg = '{8'h31, 8'h78, 8'h30, 8'h20, 8'h30, 8'h31, 8'h78, 8'h31, 8'h20, 8'h30, 8'h31, 8'h31};
        expQ = expectedPrint("11011001");
        validCount = 0;
        idle(2);
        strobeQ.delete(); strobeCyc.delete();
        for (int i = 0; i < msg.size(); i++) begin
            if (msg[i] == 8'h30 || msg[i] == 8'h31) validCount++;
            sendChar(msg[i], cnt, cyc);
            checks++; if (cnt !== 4'(validCount)) begin failures++; $display("[TB] FAIL filter_counter idx=%0d got=%0d exp=%0d", i, cnt, validCount); end
            if (i < msg.size() - 1) idle(4);
        end
        waitStrobes(10, 100, reached);
        checks++; if (!reached || strobeQ.size() != 10) begin failures++; $display("[TB] FAIL filter_count got=%0d exp=10", strobeQ.size()); end
        for (int i = 0; i < strobeQ.size() && i < 10; i++) begin
            checks++; if (strobeQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL filter_char%0d got=%0h exp=%0h", i, strobeQ[i], expQ[i]); end
        end
    endtask

    task automatic test_backpressure();
        charQ_t msg;
        charQ_t expQ;
        logic [3:0] cnt;
        int cyc;
        bit reached;
        msg = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h31, 8'h31, 8'h31};
        expQ = expectedPrint("11110000");
        idle(2);
        strobeQ.delete(); strobeCyc.delete();
        for (int i = 0; i < 8; i++) begin
            sendChar(msg[i], cnt, cyc);
            if (i < 7) idle(4);
        end
        waitStrobes(3, 50, reached);
        checks++; if (!reached) begin failures++; $display("[TB] FAIL bp_first3 got=%0d exp=3", strobeQ.size()); end
        tx_busy = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); #1;
            checks++; if (strobeQ.size() != 3 || addr !== 4'd3 || new_tx_data !== 1'b0) begin failures++; $display("[TB] FAIL bp_hold cyc=%0d got=%0d/%0d exp=3/3", t, strobeQ.size(), addr); end
        end
        tx_busy = 1'b0;
        waitStrobes(10, 100, reached);
        idle(4);
        checks++; if (!reached || strobeQ.size() != 10) begin failures++; $display("[TB] FAIL bp_count got=%0d exp=10", strobeQ.size()); end
        for (int i = 0; i < strobeQ.size() && i < 10; i++) begin
            checks++; if (strobeQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL bp_char%0d got=%0h exp=%0h", i, strobeQ[i], expQ[i]); end
        end
    endtask

    task automatic test_reset_mid_print();
        charQ_t msg;
        charQ_t expQ;
        logic [3:0] cnt;
        int cyc;
        bit reached;
        msg = '{8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31};
        idle(2);
        strobeQ.delete(); strobeCyc.delete();
        for (int i = 0; i < 8; i++) begin
            sendChar(msg[i], cnt, cyc);
            if (i < 7) idle(4);
        end
        waitStrobes(3, 50, reached);
        checks++; if (!reached) begin failures++; $display("[TB] FAIL midrst_first3 got=%0d exp=3", strobeQ.size()); end
        rst = 1'b0;
        #1;
        checks++; if (new_tx_data !== 1'b0 || state !== 1'b0 || addr !== 4'd0) begin failures++; $display("[TB] FAIL midrst_abort got=%0b/%0b/%0d exp=0/0/0", new_tx_data, state, addr); end
        repeat (5) @(negedge clk);
        #1;
        checks++; if (strobeQ.size() != 3) begin failures++; $display("[TB] FAIL midrst_no_more got=%0d exp=3", strobeQ.size()); end
        rst = 1'b1;
        msg = '{8'h30, 8'h31, 8'h31, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30};
        expQ = expectedPrint("00000110");
        idle(2);
        strobeQ.delete(); strobeCyc.delete();
        for (int i = 0; i < 8; i++) begin
            sendChar(msg[i], cnt, cyc);
            if (i < 7) idle(4);
        end
        waitStrobes(10, 100, reached);
        checks++; if (!reached || strobeQ.size() != 10) begin failures++; $display("[TB] FAIL midrst_count got=%0d exp=10", strobeQ.size()); end
        for (int i = 0; i < strobeQ.size() && i < 10; i++) begin
            checks++; if (strobeQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL midrst_char%0d got=%0h exp=%0h", i, strobeQ[i], expQ[i]); end
        end
    endtask

    // Run all scenarios in order, then report
    initial begin
        test_reset();
        test_basic();
        test_asymmetric();
        test_filtering();
        test_backpressure();
        test_reset_mid_print();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_reverse_printer.md
Name: bit_reverse_printer

Overview:
- UART-side message block for the bit-reversal demo.
- Accepts eight ASCII '0'/'1' characters from the UART receiver and assembles them into a byte, first character as MSB.
- Bit-reverses that byte and prints it back through the UART transmitter as eight ASCII '0'/'1' characters followed by CR LF.
- Sits between the UART rx/tx cores and exposes internal state, address and counter for debug.

Parameters:
- NUM_BITS, 8, characters collected per message and bits printed; fixed at 8, counter/addr widths sized for it.
- SEND_CRLF, 1, when 1 append 8'h0D, 8'h0A after the bit characters; when 0 print bits only.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- tx_data  out  8  character to transmit; valid when new_tx_data=1.
- new_tx_data  out  1  one-cycle strobe to the UART transmitter.
- tx_busy  in  1  transmitter busy; no strobe issued while 1.
- new_rx_data  in  1  one-cycle strobe; rx_data is valid this cycle.
- rx_data  in  8  received ASCII character.
- state  out  1  0 = RECEIVE, 1 = PRINT.
- addr  out  4  index of the next character to print (0..9).
- bytes  out  1  reversed-byte bit selected by addr (0 when addr >= 8).
- counter  out  4  number of valid bits received so far (0..8).

Behaviour:
- Reset (rst=0, async): state=RECEIVE, counter=0, addr=0, shift register=0, reversed register=0, tx_data=0, new_tx_data=0, bytes=0. A reset during PRINT aborts the message with no further strobes.
- RECEIVE, on a cycle with new_rx_data=1:
  - rx_data=8'h31 ('1') or 8'h30 ('0'): shift register <= {sr[6:0], rx_data[0]}; counter++.
  - Any other character is ignored; counter is unchanged and nothing is echoed.
- Each high cycle of new_rx_data counts as one character; the upstream UART guarantees single-cycle strobes.
- When counter reaches 8 (the cycle after the 8th valid char):
  - Reversed register <= bit-reverse of the shift register (out[i] = sr[7-i]).
  - addr=0, counter=0, state=PRINT.
- PRINT:
  - When tx_busy=0 and no strobe was issued the previous cycle, drive new_tx_data=1 for one cycle.
  - For addr 0..7, tx_data = rev[7-addr] ? 8'h31 : 8'h30 (reversed byte MSB first).
  - For addr 8 and 9 (SEND_CRLF=1), tx_data = 8'h0D then 8'h0A.
  - addr increments the cycle after each strobe.
  - The mandatory gap cycle between strobes lets tx_busy rise. With tx_busy held 0, strobes occur every 2 cycles.
- Last character issued (addr 9, or addr 7 with SEND_CRLF=0): return to RECEIVE, addr=0.
- new_rx_data during PRINT is dropped; counter stays 0.
- tx_data holds its last value between strobes.
- bytes is combinational from the reversed register and addr.
- Latency: the first strobe comes 2 cycles after the 8th valid rx strobe when tx_busy=0.

Decomposition:
- Shared package:
  - ASCII constants CHAR_0=8'h30, CHAR_1=8'h31, CHAR_CR=8'h0D, CHAR_LF=8'h0A.
  - State enum {RECEIVE, PRINT}.
- One natural sub-module: bit_reverse8, a purely combinational 8-bit reverser.
- Everything else stays in the top FSM.

Test Plan:
- Reset: hold rst=0 with new_rx_data pulses applied → all outputs 0, counter=0, no strobes. Release → state=RECEIVE.
- Basic: send "1","0","1","0","1","0","1","0" as single-cycle strobes 5 cycles apart, tx_busy=0 → counter steps 1..8 then 0, state=1. Strobes carry "01010101" then 0x0D, 0x0A, 2 cycles apart. Then state=0, addr=0.
- Asymmetric: send "1","1","0","0","0","0","0","0" (0xC0) → printed "00000011\r\n"; bytes=1 while addr=6 and 7.
- Filtering: interleave 'x' (0x78) and 0x20 among eight valid chars → invalid chars leave counter unchanged; output matches the valid chars only.
- Backpressure: hold tx_busy=1 for 20 cycles during PRINT → no strobe, addr frozen. Release → resumes at the same addr, no character lost or repeated.
- Reset mid-print: assert rst after 3 characters printed → strobes stop immediately, addr=0, state=0. A following 8-char message prints correctly.
